reg_file_sb: RTL

//  Parametrised integer register file for the pipelined core. Two combinational read

---
 rtl/reg_file_sb.sv | 90 +++++++++
 1 files changed

// File: rtl/reg_file_sb.sv
// Integer register file: two combinational read ports, one write-back port and a per-register pending scoreboard.
// Optional write-through forwarding from write-back to the read ports is enabled by defining RF_BYPASS_EN.

module reg_file_sb_cell #(
  parameter int              XLEN    = 32,
  parameter logic [XLEN-1:0] RST_VAL = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wr_hit,
  input  logic            iss_hit,
  input  logic [XLEN-1:0] wr_data,
  output logic [XLEN-1:0] q,
  output logic            pend
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q    <= RST_VAL;
      pend <= 1'b0;
    end else begin
      if (wr_hit) q <= wr_data;
      // A new producer issued on the same edge as the old one retires stays in flight.
      if (iss_hit)     pend <= 1'b1;
      else if (wr_hit) pend <= 1'b0;
    end
  end
endmodule

module reg_file_sb #(
  parameter  int XLEN    = 32,
  parameter  int NREGS   = 32,
  parameter  int SP_INIT = 1023,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic            rs1_busy,
  output logic            rs2_busy,
  input  logic            iss_en,
  input  logic [AW-1:0]   iss_rd,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic [XLEN-1:0] wr_data
);
  localparam logic [XLEN-1:0] SPV = XLEN'(SP_INIT);

  logic [NREGS-1:0][XLEN-1:0] regs;
  logic [NREGS-1:0]           pend;

  for (genvar g = 0; g < NREGS; g++) begin : g_reg
    if (g == 0) begin : g_zero
      assign regs[g] = '0;
      assign pend[g] = 1'b0;
    end else begin : g_cell
      reg_file_sb_cell #(
        .XLEN    (XLEN),
        .RST_VAL ((g == 2) ? SPV : {XLEN{1'b0}})
      ) u_cell (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_hit  (wr_en  && (wr_addr == AW'(g))),
        .iss_hit (iss_en && (iss_rd  == AW'(g))),
        .wr_data (wr_data),
        .q       (regs[g]),
        .pend    (pend[g])
      );
    end
  end

`ifdef RF_BYPASS_EN
  logic byp1, byp2;
  assign byp1 = wr_en && (wr_addr != '0) && (wr_addr == rs1_addr);
  assign byp2 = wr_en && (wr_addr != '0) && (wr_addr == rs2_addr);

  assign rs1_data = byp1 ? wr_data : regs[rs1_addr];
  assign rs2_data = byp2 ? wr_data : regs[rs2_addr];
  assign rs1_busy = !byp1 && pend[rs1_addr];
  assign rs2_busy = !byp2 && pend[rs2_addr];
`else
  assign rs1_data = regs[rs1_addr];
  assign rs2_data = regs[rs2_addr];
  assign rs1_busy = pend[rs1_addr];
  assign rs2_busy = pend[rs2_addr];
`endif

endmodule
